// File: rtl/pipe_sequencer.sv
// Single-issue fetch/issue sequencer with a 4-deep return stack; one instruction in flight,
// INST_VLD the cycle after IMEM_RDY (or FLAG_VLD for conditionals); STALL_IN holds ISSUE.
module pipe_sequencer #(
  parameter logic [9:0] RESET_VEC = 10'h000,
  parameter logic [3:0] JMP_OP    = 4'h9,
  parameter logic [3:0] JZE_OP    = 4'hA,
  parameter logic [3:0] JNE_OP    = 4'hB,
  parameter logic [3:0] JCY_OP    = 4'hC,
  parameter logic [3:0] BSR_OP    = 4'h1,
  parameter logic [3:0] RET_OP    = 4'h8
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [9:0]  PC,
  output logic        IFETCH_REQ,
  input  logic        IMEM_RDY,
  input  logic [19:0] INST_IN,
  output logic [19:0] INST_OUT,
  output logic        INST_VLD,
  input  logic        STALL_IN,
  input  logic        FLAG_VLD,
  input  logic        ZF,
  input  logic        CF,
  output logic        STK_ERR
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_FLAG = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  pc;
  logic [9:0]  pc_nxt;
  logic [9:0]  pc_inc;
  logic [19:0] ir;
  logic        taken;
  logic        taken_nxt;
  logic        stk_err;
  logic [9:0]  stack [4];
  logic [2:0]  depth;
  logic [1:0]  top_idx;
  logic [3:0]  op;
  logic [3:0]  op_in;
  logic        in_is_cond;
  logic        is_cond;
  logic        is_bsr;
  logic        is_ret;
  logic        stk_fault;
  logic        xfer;

  assign op         = ir[19:16];
  assign op_in      = INST_IN[19:16];
  assign in_is_cond = (op_in == JZE_OP) || (op_in == JNE_OP) || (op_in == JCY_OP);
  assign is_cond    = (op == JZE_OP) || (op == JNE_OP) || (op == JCY_OP);
  assign is_bsr     = (op == BSR_OP);
  assign is_ret     = (op == RET_OP);
  assign pc_inc     = pc + 10'd1;
  // depth 1..4 maps to 0..3; the 2-bit wrap makes depth=4 land on entry 3
  assign top_idx    = depth[1:0] - 2'd1;

  // Built only from registered state so outputs never see an input combinationally
  assign stk_fault = (state == ISSUE) &&
                     ((is_bsr && (depth == 3'd4)) || (is_ret && (depth == 3'd0)));
  assign xfer      = (state == ISSUE) && !stk_fault && !STALL_IN;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     if (IMEM_RDY) state_nxt = in_is_cond ? WAIT_FLAG : ISSUE;
      WAIT_FLAG: if (FLAG_VLD) state_nxt = ISSUE;
      ISSUE: begin
        if (stk_fault)      state_nxt = HALT;
        else if (!STALL_IN) state_nxt = FETCH;
      end
      HALT:      state_nxt = HALT;
      default:   state_nxt = FETCH;
    endcase
  end

  always_comb begin
    taken_nxt = 1'b0;
    if (op == JZE_OP)      taken_nxt = ZF;
    else if (op == JNE_OP) taken_nxt = !ZF;
    else if (op == JCY_OP) taken_nxt = CF;
  end

  always_comb begin
    pc_nxt = pc_inc;
    if (op == JMP_OP)  pc_nxt = ir[9:0];
    else if (is_cond)  pc_nxt = taken ? ir[9:0] : pc_inc;
    else if (is_bsr)   pc_nxt = ir[9:0];
    else if (is_ret)   pc_nxt = stack[top_idx];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc      <= RESET_VEC;
      ir      <= 20'h00000;
      depth   <= 3'd0;
      taken   <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      if ((state == FETCH) && IMEM_RDY)     ir <= INST_IN;
      if ((state == WAIT_FLAG) && FLAG_VLD) taken <= taken_nxt;
      if (stk_fault)                        stk_err <= 1'b1;
      if (xfer) begin
        pc <= pc_nxt;
        if (is_bsr)      depth <= depth + 3'd1;
        else if (is_ret) depth <= depth - 3'd1;
      end
    end
  end

  // Stack contents need no reset: depth alone says which entries are live
  always_ff @(posedge CLK) begin
    if (RST_N && xfer && is_bsr) stack[depth[1:0]] <= pc_inc;
  end

  assign PC         = pc;
  assign IFETCH_REQ = (state == FETCH);
  assign INST_OUT   = ir;
  assign INST_VLD   = (state == ISSUE) && !stk_fault;
  assign STK_ERR    = stk_err;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: vector table for single instructions plus
// hand sequences for stall, return-stack overflow/underflow and mid-operation reset.
module tb_pipe_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  PC;
  logic        IFETCH_REQ;
  logic        IMEM_RDY = 1'b0;
  logic [19:0] INST_IN = 20'h00000;
  logic [19:0] INST_OUT;
  logic        INST_VLD;
  logic        STALL_IN = 1'b0;
  logic        FLAG_VLD = 1'b0;
  logic        ZF = 1'b0;
  logic        CF = 1'b0;
  logic        STK_ERR;

  int checks = 0;
  int errors = 0;

  pipe_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .PC(PC), .IFETCH_REQ(IFETCH_REQ),
    .IMEM_RDY(IMEM_RDY), .INST_IN(INST_IN), .INST_OUT(INST_OUT),
    .INST_VLD(INST_VLD), .STALL_IN(STALL_IN), .FLAG_VLD(FLAG_VLD),
    .ZF(ZF), .CF(CF), .STK_ERR(STK_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [19:0] inst;
    logic        zf;
    logic        cf;
    int          flag_dly;
    logic [9:0]  pc_exp;
    logic [9:0]  pc_nxt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_cond(input logic [19:0] inst);
    return (inst[19:16] == 4'hA) || (inst[19:16] == 4'hB) || (inst[19:16] == 4'hC);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic do_fetch(input logic [19:0] inst);
    IMEM_RDY = 1'b1;
    INST_IN  = inst;
    tick();
    IMEM_RDY = 1'b0;
    INST_IN  = 20'hFFFFF;
  endtask

  task automatic run_inst(input vec_t v, input string tag);
    chk({tag, "_ifetch"}, IFETCH_REQ, 1);
    chk({tag, "_pc_before"}, PC, v.pc_exp);
    do_fetch(v.inst);
    if (is_cond(v.inst)) begin
      ZF = ~v.zf;
      CF = ~v.cf;
      chk({tag, "_wait_vld"}, INST_VLD, 0);
      repeat (v.flag_dly) tick();
      chk({tag, "_wait_ifetch"}, IFETCH_REQ, 0);
      FLAG_VLD = 1'b1;
      ZF = v.zf;
      CF = v.cf;
      tick();
      FLAG_VLD = 1'b0;
      ZF = ~v.zf;
      CF = ~v.cf;
    end
    chk({tag, "_vld"}, INST_VLD, 1);
    chk({tag, "_inst_out"}, INST_OUT, v.inst);
    tick();
    chk({tag, "_pc_after"}, PC, v.pc_nxt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          inst       zf    cf    dly pc_exp   pc_nxt
    tbl[0]  = '{20'h70005, 1'b0, 1'b0, 0, 10'h000, 10'h001};
    tbl[1]  = '{20'h90005, 1'b0, 1'b0, 0, 10'h001, 10'h005};
    tbl[2]  = '{20'hB0040, 1'b0, 1'b0, 2, 10'h005, 10'h040};
    tbl[3]  = '{20'h90005, 1'b0, 1'b0, 0, 10'h040, 10'h005};
    tbl[4]  = '{20'hB0040, 1'b1, 1'b0, 2, 10'h005, 10'h006};
    tbl[5]  = '{20'hA0010, 1'b1, 1'b0, 0, 10'h006, 10'h010};
    tbl[6]  = '{20'hA0020, 1'b0, 1'b1, 1, 10'h010, 10'h011};
    tbl[7]  = '{20'hC03FF, 1'b0, 1'b0, 1, 10'h011, 10'h012};
    tbl[8]  = '{20'hC03FF, 1'b0, 1'b1, 3, 10'h012, 10'h3FF};
    tbl[9]  = '{20'h00000, 1'b0, 1'b0, 0, 10'h3FF, 10'h000};
    tbl[10] = '{20'h90020, 1'b0, 1'b0, 0, 10'h000, 10'h020};
    tbl[11] = '{20'h10100, 1'b0, 1'b0, 0, 10'h020, 10'h100};
    tbl[12] = '{20'h80000, 1'b0, 1'b0, 0, 10'h100, 10'h021};
    tbl[13] = '{20'hD0123, 1'b0, 1'b0, 0, 10'h021, 10'h022};

    // Reset state
    do_reset();
    chk("rst_ifetch", IFETCH_REQ, 1);
    chk("rst_vld", INST_VLD, 0);
    chk("rst_stkerr", STK_ERR, 0);
    chk("rst_pc", PC, 10'h000);

    // Table: one instruction per row, PC chained through the rows
    for (int i = 0; i < 14; i++)
      run_inst(tbl[i], $sformatf("vec%0d", i));

    // Stall in ISSUE for three cycles, transfer on the fourth
    do_reset();
    do_fetch(20'h70005);
    STALL_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_vld", i), INST_VLD, 1);
      chk($sformatf("stall%0d_out", i), INST_OUT, 20'h70005);
      chk($sformatf("stall%0d_pc", i), PC, 10'h000);
      chk($sformatf("stall%0d_ifetch", i), IFETCH_REQ, 0);
      tick();
    end
    STALL_IN = 1'b0;
    chk("stall_last_vld", INST_VLD, 1);
    tick();
    chk("stall_xfer_pc", PC, 10'h001);
    chk("stall_xfer_ifetch", IFETCH_REQ, 1);

    // Overflow: four nested calls fit, the fifth halts
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = '{20'h10000 | 20'((i + 1) * 16), 1'b0, 1'b0, 0, 10'(i * 16), 10'((i + 1) * 16)};
      run_inst(v, $sformatf("bsr%0d", i));
    end
    do_fetch(20'h10050);
    chk("ovf_vld", INST_VLD, 0);
    chk("ovf_stkerr_pre", STK_ERR, 0);
    tick();
    chk("ovf_stkerr", STK_ERR, 1);
    chk("ovf_halt_ifetch", IFETCH_REQ, 0);
    chk("ovf_pc_held", PC, 10'h040);
    IMEM_RDY = 1'b1;
    INST_IN  = 20'h70001;
    repeat (2) tick();
    IMEM_RDY = 1'b0;
    chk("halt_stays_vld", INST_VLD, 0);
    chk("halt_stays_ifetch", IFETCH_REQ, 0);
    chk("halt_stays_stkerr", STK_ERR, 1);
    do_reset();
    chk("ovf_rst_pc", PC, 10'h000);
    chk("ovf_rst_stkerr", STK_ERR, 0);
    chk("ovf_rst_ifetch", IFETCH_REQ, 1);

    // Underflow: return with an empty stack
    do_fetch(20'h80000);
    chk("unf_vld", INST_VLD, 0);
    tick();
    chk("unf_stkerr", STK_ERR, 1);
    chk("unf_ifetch", IFETCH_REQ, 0);
    chk("unf_pc", PC, 10'h000);

    // Reset while parked in WAIT_FLAG
    do_reset();
    v = '{20'h90123, 1'b0, 1'b0, 0, 10'h000, 10'h123};
    run_inst(v, "pre_wf_jmp");
    do_fetch(20'hA0033);
    chk("wf_ifetch", IFETCH_REQ, 0);
    chk("wf_vld", INST_VLD, 0);
    do_reset();
    chk("wf_rst_pc", PC, 10'h000);
    chk("wf_rst_ifetch", IFETCH_REQ, 1);
    chk("wf_rst_vld", INST_VLD, 0);
    chk("wf_rst_stkerr", STK_ERR, 0);
    v = '{20'hA0033, 1'b1, 1'b0, 1, 10'h000, 10'h033};
    run_inst(v, "post_wf_jze");

    // Reset while stalled in ISSUE
    do_fetch(20'h70009);
    STALL_IN = 1'b1;
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    STALL_IN = 1'b0;
    chk("stall_rst_pc", PC, 10'h000);
    chk("stall_rst_vld", INST_VLD, 0);
    chk("stall_rst_ifetch", IFETCH_REQ, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
